// File: rtl/neo_m68k_pkg.sv
// Shared state encoding, timing constants and state-phase decoders for the
// 68000 bus master.
package neo_m68k_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

    // Each state is one 68000 half-state (one CLK_68KCLK period); SW repeats.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_SW,
        ST_S5,
        ST_S6,
        ST_S7
    } bus_state_e;

    function automatic logic as_phase(input bus_state_e s);
        return s inside {ST_S2, ST_S3, ST_S4, ST_SW, ST_S5, ST_S6};
    endfunction

    function automatic logic wr_strobe_phase(input bus_state_e s);
        return s inside {ST_S4, ST_SW, ST_S5, ST_S6};
    endfunction

    function automatic logic rw_low_phase(input bus_state_e s);
        return s inside {ST_S2, ST_S3, ST_S4, ST_SW, ST_S5, ST_S6, ST_S7};
    endfunction

    function automatic logic data_oe_phase(input bus_state_e s);
        return s inside {ST_S3, ST_S4, ST_SW, ST_S5, ST_S6, ST_S7};
    endfunction

    function automatic logic dtack_phase(input bus_state_e s);
        return s inside {ST_S4, ST_SW};
    endfunction

endpackage

// File: rtl/m68k_bus_timeout.sv
// Bus-error watchdog: counts S4/SW clocks spent waiting on nDTACK and flags
// the clock in which the TIMEOUT-th waiting clock occurs.
module m68k_bus_timeout #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is seen combinationally so the abort lands on the TIMEOUT-th clock.
    assign expired_o = count_en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 asynchronous bus master: runs one read or write bus cycle per command
// with nDTACK wait states and a bus-error timeout.
module m68k_bus_master
    import neo_m68k_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK_68KCLK,
    input  logic        nRESET,
    input  logic        CMD_REQ,
    input  logic        CMD_RW,
    input  logic [22:0] CMD_ADDR,
    input  logic [1:0]  CMD_BE,
    input  logic [15:0] CMD_WDATA,
    output logic        CMD_BUSY,
    output logic        CMD_DONE,
    output logic        CMD_ERR,
    output logic [15:0] CMD_RDATA,
    output logic [22:0] M68K_ADDR,
    output logic [15:0] M68K_DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] M68K_DATA_IN,
    output logic        nAS,
    output logic        nUDS,
    output logic        nLDS,
    output logic        RW,
    input  logic        nDTACK
);

    bus_state_e  state_q, state_d;
    logic        rw_q;
    logic [1:0]  be_q;
    logic [22:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        nas_q, nuds_q, nlds_q, rw_out_q, oe_q;
    logic        busy_q, done_q, err_q;

    logic        accept, reject;
    logic        waiting, tmo_expired, tmo_abort;
    logic        strobe_on;
    logic [15:0] rdata_masked;

    assign waiting = dtack_phase(state_q);

    m68k_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i      (CLK_68KCLK),
        .rst_ni     (nRESET),
        .clear_i    (!waiting),
        .count_en_i (waiting && nDTACK),
        .expired_o  (tmo_expired)
    );

    assign tmo_abort = waiting && nDTACK && tmo_expired;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CMD_REQ) begin
                    if (CMD_BE != 2'b00) begin
                        accept  = 1'b1;
                        state_d = ST_S0;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            ST_S0: state_d = ST_S1;
            ST_S1: state_d = ST_S2;
            ST_S2: state_d = ST_S3;
            ST_S3: state_d = ST_S4;
            ST_S4, ST_SW: begin
                if (!nDTACK) begin
                    state_d = ST_S5;
                end else if (tmo_expired) begin
                    state_d = ST_S7;
                end else begin
                    state_d = ST_SW;
                end
            end
            ST_S5: state_d = ST_S6;
            ST_S6: state_d = ST_S7;
            ST_S7: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pins are registered from the next state so they track state_q exactly.
    assign strobe_on    = rw_q ? as_phase(state_d) : wr_strobe_phase(state_d);
    assign rdata_masked = {be_q[1] ? M68K_DATA_IN[15:8] : 8'h00,
                           be_q[0] ? M68K_DATA_IN[7:0]  : 8'h00};

    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b1;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            nas_q    <= 1'b1;
            nuds_q   <= 1'b1;
            nlds_q   <= 1'b1;
            rw_out_q <= 1'b1;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rw_q   <= CMD_RW;
                be_q   <= CMD_BE;
                addr_q <= CMD_ADDR;
                if (!CMD_RW) begin
                    wdata_q <= CMD_WDATA;
                end
            end
            nas_q    <= !as_phase(state_d);
            nuds_q   <= !(strobe_on && be_q[1]);
            nlds_q   <= !(strobe_on && be_q[0]);
            rw_out_q <= !(!rw_q && rw_low_phase(state_d));
            oe_q     <= !rw_q && data_oe_phase(state_d);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= reject || (state_d == ST_S7);
            err_q    <= reject || tmo_abort;
            if (rw_q && (state_q == ST_S6)) begin
                rdata_q <= rdata_masked;
            end else if (rw_q && tmo_abort) begin
                rdata_q <= '0;
            end
        end
    end

    assign CMD_BUSY      = busy_q;
    assign CMD_DONE      = done_q;
    assign CMD_ERR       = err_q;
    assign CMD_RDATA     = rdata_q;
    assign M68K_ADDR     = addr_q;
    assign M68K_DATA_OUT = wdata_q;
    assign DATA_OE       = oe_q;
    assign nAS           = nas_q;
    assign nUDS          = nuds_q;
    assign nLDS          = nlds_q;
    assign RW            = rw_out_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Scoreboard bench for m68k_bus_master: directed commands push expected
// completions, a negedge monitor counts bus activity and checks each CMD_DONE.
module tb_m68k_bus_master;

    logic        CLK_68KCLK = 1'b0;
    logic        nRESET;
    logic        CMD_REQ;
    logic        CMD_RW;
    logic [22:0] CMD_ADDR;
    logic [1:0]  CMD_BE;
    logic [15:0] CMD_WDATA;
    logic        CMD_BUSY;
    logic        CMD_DONE;
    logic        CMD_ERR;
    logic [15:0] CMD_RDATA;
    logic [22:0] M68K_ADDR;
    logic [15:0] M68K_DATA_OUT;
    logic        DATA_OE;
    logic [15:0] M68K_DATA_IN;
    logic        nAS;
    logic        nUDS;
    logic        nLDS;
    logic        RW;
    logic        nDTACK = 1'b1;

    m68k_bus_master #(.TIMEOUT(64)) dut (
        .CLK_68KCLK    (CLK_68KCLK),
        .nRESET        (nRESET),
        .CMD_REQ       (CMD_REQ),
        .CMD_RW        (CMD_RW),
        .CMD_ADDR      (CMD_ADDR),
        .CMD_BE        (CMD_BE),
        .CMD_WDATA     (CMD_WDATA),
        .CMD_BUSY      (CMD_BUSY),
        .CMD_DONE      (CMD_DONE),
        .CMD_ERR       (CMD_ERR),
        .CMD_RDATA     (CMD_RDATA),
        .M68K_ADDR     (M68K_ADDR),
        .M68K_DATA_OUT (M68K_DATA_OUT),
        .DATA_OE       (DATA_OE),
        .M68K_DATA_IN  (M68K_DATA_IN),
        .nAS           (nAS),
        .nUDS          (nUDS),
        .nLDS          (nLDS),
        .RW            (RW),
        .nDTACK        (nDTACK)
    );

    always #5 CLK_68KCLK = ~CLK_68KCLK;

    typedef struct {
        logic        err;
        logic        chk_addr;
        logic [22:0] addr;
        logic        chk_rd;
        logic [15:0] rdata;
        logic        chk_wd;
        logic [15:0] wdata;
        int          busy;
        int          as_n;
        int          uds_n;
        int          lds_n;
        int          oe_n;
        int          rwl_n;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   dtack_wait = 0;
    logic b2b_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK_68KCLK) cyc++;

    // Decoder model: DTACK asserted once nAS has been low for 3 + dtack_wait clocks.
    int as_run = 0;
    always @(negedge CLK_68KCLK) begin
        if (nAS) begin
            as_run = 0;
            nDTACK = 1'b1;
        end else begin
            as_run++;
            nDTACK = !(as_run >= 3 + dtack_wait);
        end
    end

    // Monitor: accumulate per-transaction activity, compare on every CMD_DONE.
    int   m_busy = 0, m_as = 0, m_uds = 0, m_lds = 0, m_oe = 0, m_rwl = 0;
    int   last_fall = -1;
    logic prev_nas = 1'b1;
    always @(negedge CLK_68KCLK) begin
        exp_t e;
        if (!nRESET) begin
            m_busy = 0; m_as = 0; m_uds = 0; m_lds = 0; m_oe = 0; m_rwl = 0;
            prev_nas = 1'b1;
        end else begin
            if (CMD_BUSY) m_busy++;
            if (!nAS)     m_as++;
            if (!nUDS)    m_uds++;
            if (!nLDS)    m_lds++;
            if (DATA_OE)  m_oe++;
            if (!RW)      m_rwl++;
            if (!b2b_mode) begin
                last_fall = -1;
            end else if (!nAS && prev_nas) begin
                if (last_fall >= 0) check("b2b_nas_period", 64'(cyc - last_fall), 64'd9);
                last_fall = cyc;
            end
            prev_nas = nAS;
            if (CMD_DONE) begin
                check("done_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("err", 64'(CMD_ERR), 64'(e.err));
                    if (e.chk_addr) check("addr", 64'(M68K_ADDR), 64'(e.addr));
                    if (e.chk_rd)   check("rdata", 64'(CMD_RDATA), 64'(e.rdata));
                    if (e.chk_wd)   check("wdata", 64'(M68K_DATA_OUT), 64'(e.wdata));
                    check("busy_clks", 64'(m_busy), 64'(e.busy));
                    check("nas_clks",  64'(m_as),   64'(e.as_n));
                    check("nuds_clks", 64'(m_uds),  64'(e.uds_n));
                    check("nlds_clks", 64'(m_lds),  64'(e.lds_n));
                    check("oe_clks",   64'(m_oe),   64'(e.oe_n));
                    check("rwlow_clks",64'(m_rwl),  64'(e.rwl_n));
                    check("done_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                end
                m_busy = 0; m_as = 0; m_uds = 0; m_lds = 0; m_oe = 0; m_rwl = 0;
            end
        end
    end

    function automatic exp_t mk(input logic rw, input logic [23:0] ba, input logic [1:0] be,
                                input logic [15:0] wd, input logic err, input logic [15:0] rd,
                                input int busy, input int as_n, input int uds_n, input int lds_n,
                                input int oe_n, input int rwl_n, input int lat);
        exp_t e;
        e.err = err; e.chk_addr = (be != 2'b00); e.addr = ba[23:1];
        e.chk_rd = rw && (be != 2'b00); e.rdata = rd;
        e.chk_wd = !rw && (be != 2'b00); e.wdata = wd;
        e.busy = busy; e.as_n = as_n; e.uds_n = uds_n; e.lds_n = lds_n;
        e.oe_n = oe_n; e.rwl_n = rwl_n; e.lat = lat; e.acc_cyc = 0;
        return e;
    endfunction

    task automatic wait_done(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            if (CMD_DONE) seen++;
            if (seen < n) @(negedge CLK_68KCLK);
        end
        check("done_within_budget", 64'(seen), 64'(n));
    endtask

    task automatic issue(input logic rw, input logic [23:0] ba, input logic [1:0] be,
                         input logic [15:0] wd, input int waits, input logic [15:0] din,
                         input int pulse_at, input exp_t e_in);
        exp_t e;
        e = e_in;
        @(negedge CLK_68KCLK);
        dtack_wait   = waits;
        M68K_DATA_IN = din;
        CMD_REQ = 1'b1; CMD_RW = rw; CMD_ADDR = ba[23:1]; CMD_BE = be; CMD_WDATA = wd;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge CLK_68KCLK);
        CMD_REQ = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at) @(negedge CLK_68KCLK);
            CMD_REQ = 1'b1; CMD_RW = ~rw; CMD_ADDR = ~CMD_ADDR; CMD_BE = 2'b11; CMD_WDATA = 16'hDEAD;
            @(negedge CLK_68KCLK);
            CMD_REQ = 1'b0;
        end
        wait_done(1, 200);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_nAS"},  64'(nAS),  64'd1);
        check({tag, "_nUDS"}, 64'(nUDS), 64'd1);
        check({tag, "_nLDS"}, 64'(nLDS), 64'd1);
        check({tag, "_RW"},   64'(RW),   64'd1);
        check({tag, "_OE"},   64'(DATA_OE),  64'd0);
        check({tag, "_BUSY"}, 64'(CMD_BUSY), 64'd0);
        check({tag, "_DONE"}, 64'(CMD_DONE), 64'd0);
        check({tag, "_ERR"},  64'(CMD_ERR),  64'd0);
        check({tag, "_RDATA"},64'(CMD_RDATA),    64'd0);
        check({tag, "_ADDR"}, 64'(M68K_ADDR),    64'd0);
        check({tag, "_DOUT"}, 64'(M68K_DATA_OUT),64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        exp_t e;
        nRESET = 1'b1; CMD_REQ = 1'b0; CMD_RW = 1'b1; CMD_ADDR = '0; CMD_BE = '0;
        CMD_WDATA = '0; M68K_DATA_IN = '0;
        #1 nRESET = 1'b0;
        #2 check_reset_state("por");
        @(negedge CLK_68KCLK); @(negedge CLK_68KCLK);
        #2 nRESET = 1'b1;

        // rw, byte addr, be, wdata, waits, din, pulse; err, rdata, busy, as, uds, lds, oe, rwl, lat
        issue(1, 24'h100000, 2'b11, 16'h0000, 0, 16'hA55A, 0,
              mk(1, 24'h100000, 2'b11, 16'h0000, 0, 16'hA55A, 8, 5, 5, 5, 0, 0, 7));
        issue(0, 24'h200002, 2'b01, 16'h1234, 3, 16'h0000, 0,
              mk(0, 24'h200002, 2'b01, 16'h1234, 0, 16'h0000, 11, 8, 0, 6, 8, 9, 10));
        issue(1, 24'h0ABCDE, 2'b10, 16'h0000, 2, 16'hBEEF, 0,
              mk(1, 24'h0ABCDE, 2'b10, 16'h0000, 0, 16'hBE00, 10, 7, 7, 0, 0, 0, 9));
        issue(1, 24'hFFFFFE, 2'b01, 16'h0000, 0, 16'hBEEF, 0,
              mk(1, 24'hFFFFFE, 2'b01, 16'h0000, 0, 16'h00EF, 8, 5, 0, 5, 0, 0, 7));
        issue(1, 24'h300000, 2'b11, 16'h0000, 1000, 16'hFFFF, 0,
              mk(1, 24'h300000, 2'b11, 16'h0000, 1, 16'h0000, 69, 66, 66, 66, 0, 0, 68));
        issue(0, 24'h300010, 2'b11, 16'h5A5A, 1000, 16'h0000, 0,
              mk(0, 24'h300010, 2'b11, 16'h5A5A, 1, 16'h0000, 69, 66, 64, 64, 66, 67, 68));
        issue(1, 24'h400000, 2'b00, 16'h0000, 0, 16'h0000, 0,
              mk(1, 24'h400000, 2'b00, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
        issue(1, 24'h040000, 2'b11, 16'h0000, 0, 16'h2468, 2,
              mk(1, 24'h040000, 2'b11, 16'h0000, 0, 16'h2468, 8, 5, 5, 5, 0, 0, 7));

        // CMD_REQ held high: three reads back to back.
        @(negedge CLK_68KCLK);
        b2b_mode = 1'b1; dtack_wait = 0; M68K_DATA_IN = 16'h0F0F;
        CMD_REQ = 1'b1; CMD_RW = 1'b1; CMD_ADDR = 23'h000123; CMD_BE = 2'b11;
        base = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e = mk(1, 24'h000246, 2'b11, 16'h0000, 0, 16'h0F0F, 8, 5, 5, 5, 0, 0, 7);
            e.acc_cyc = base + 9 * i;
            sb.push_back(e);
        end
        wait_done(3, 60);
        CMD_REQ = 1'b0;
        b2b_mode = 1'b0;

        // Reset while a write waits in SW: cycle aborts with no completion.
        @(negedge CLK_68KCLK);
        dtack_wait = 1000;
        CMD_REQ = 1'b1; CMD_RW = 1'b0; CMD_ADDR = 23'h091A2B; CMD_BE = 2'b11; CMD_WDATA = 16'hCAFE;
        @(negedge CLK_68KCLK);
        CMD_REQ = 1'b0;
        repeat (6) @(negedge CLK_68KCLK);
        check("pre_reset_OE",  64'(DATA_OE), 64'd1);
        check("pre_reset_nAS", 64'(nAS), 64'd0);
        #2 nRESET = 1'b0;
        #1 check_reset_state("mid");
        @(negedge CLK_68KCLK); @(negedge CLK_68KCLK);
        #2 nRESET = 1'b1;
        repeat (3) @(negedge CLK_68KCLK);

        issue(1, 24'h0A0000, 2'b11, 16'h0000, 1, 16'h1357, 0,
              mk(1, 24'h0A0000, 2'b11, 16'h0000, 0, 16'h1357, 9, 6, 6, 6, 0, 0, 8));

        repeat (5) @(negedge CLK_68KCLK);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
